// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a one-cold column drive, samples the rows,
// debounces a single pressed key and its release, and reports one code per press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t          state;
    logic [3:0]      row_meta, rs;
    logic [1:0]      idx;
    logic [DW-1:0]   dwell;
    logic [BW-1:0]   deb_cnt;
    logic [1:0]      lat_row;
    logic [3:0]      lat_pat;

    function automatic logic one_cold(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] row_of(input logic [3:0] v);
        case (v)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Telephone-style layout: * and # sit either side of 0 on the bottom row
    function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            row_meta  <= 4'hF;
            rs        <= 4'hF;
            idx       <= 2'd0;
            dwell     <= '0;
            deb_cnt   <= '0;
            lat_row   <= 2'd0;
            lat_pat   <= 4'hF;
            col_out   <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            row_meta  <= row_in;
            rs        <= row_meta;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        // Ghosting or multi-key rows are skipped, not guessed at
                        if (one_cold(rs)) begin
                            lat_row <= row_of(rs);
                            lat_pat <= rs;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            idx     <= idx + 2'd1;
                            col_out <= col_drive(idx + 2'd1);
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rs == lat_pat) begin
                        if (deb_cnt == DEB_LAST) begin
                            key_code  <= code_of(lat_row, idx);
                            key_valid <= 1'b1;
                            deb_cnt   <= '0;
                            state     <= PRESSED;
                        end else begin
                            deb_cnt <= deb_cnt + BW'(1);
                        end
                    end else begin
                        idx     <= idx + 2'd1;
                        col_out <= col_drive(idx + 2'd1);
                        dwell   <= '0;
                        state   <= SCAN;
                    end
                end
                PRESSED: begin
                    key_held <= 1'b1;
                    if (rs == 4'hF) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                default: begin
                    // Any bounce back to a closed contact restarts the release window
                    if (rs == 4'hF) begin
                        if (deb_cnt == DEB_LAST) begin
                            key_held <= 1'b0;
                            idx      <= idx + 2'd1;
                            col_out  <= col_drive(idx + 2'd1);
                            dwell    <= '0;
                            deb_cnt  <= '0;
                            state    <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + BW'(1);
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model drives the rows from col_out,
// and a scoreboard of expected key codes is consumed on every key_valid pulse.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] pressed;   // [row][col]
    logic [3:0]      sb[$];
    int              checks;
    int              passed;
    logic            prev_valid;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // Scoreboard consumer: every pulse must match the oldest expectation and last one cycle
    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: got key_code %h, expected no pulse", key_code);
            end else begin
                logic [3:0] exp;
                exp = sb.pop_front();
                if (key_code !== exp)
                    $display("FAIL key_code: got %h expected %h", key_code, exp);
                else
                    passed++;
            end
            checks++;
            if (prev_valid)
                $display("FAIL pulse_width: got key_valid high 2 cycles expected 1");
            else
                passed++;
        end
        prev_valid <= key_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0][3:0] km(input int r, input int c);
        logic [3:0][3:0] m;
        m = '0;
        m[r][c] = 1'b1;
        return m;
    endfunction

    task automatic do_reset(input logic [3:0][3:0] keys);
        @(negedge clk);
        rst = 1'b0;
        pressed = keys;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_pulse(input int maxc, output int kk, output bit found);
        kk = 0;
        found = 1'b0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (key_valid) begin
                kk = i;
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) $display("FAIL %s: got %0d pending codes expected 0", name, sb.size());
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({col_out, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_values: got col %b code %h v %b h %b expected 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        else passed++;
    endtask

    task automatic test_scan_cycle();
        logic [3:0] e;
        do_reset('0);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            e = 4'hF;
            e[(k / 4) % 4] = 1'b0;
            checks++;
            if (col_out !== e || key_valid !== 1'b0)
                $display("FAIL scan_k%0d: got col %b v %b expected col %b v 0", k, col_out, key_valid, e);
            else passed++;
        end
    endtask

    task automatic test_press_steady();
        int kk; bit found;
        do_reset(km(1, 1));
        sb.push_back(4'h5);
        wait_pulse(100, kk, found);
        checks++;
        if (!found || kk != 16) $display("FAIL key5_latency: got found %0d cycle %0d expected cycle 16", found, kk);
        else passed++;
        checks++;
        if (key_held !== 1'b0) $display("FAIL key5_held_early: got %b expected 0", key_held);
        else passed++;
        @(negedge clk);
        checks++;
        if (key_held !== 1'b1 || col_out !== 4'b1101)
            $display("FAIL key5_held: got h %b col %b expected 1 1101", key_held, col_out);
        else passed++;
        repeat (40) @(negedge clk);
        checks++;
        if (key_held !== 1'b1 || col_out !== 4'b1101 || key_code !== 4'h5)
            $display("FAIL key5_frozen: got h %b col %b code %h expected 1 1101 5", key_held, col_out, key_code);
        else passed++;
        check_sb_empty("key5_pending");
    endtask

    task automatic test_bounce_press();
        int kk; bit found;
        do_reset(km(3, 2));
        sb.push_back(4'hF);
        found = 1'b0;
        kk = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (key_valid) begin kk = k; found = 1'b1; break; end
            if (k >= 13 && k <= 18) pressed[3][2] = (k % 2 == 0);
        end
        checks++;
        if (!found || kk < 26) $display("FAIL hash_bounce: got found %0d cycle %0d expected cycle >= 26", found, kk);
        else passed++;
        repeat (30) @(negedge clk);
        check_sb_empty("hash_pending");
    endtask

    task automatic test_release_glitch();
        int kk; bit found;
        do_reset(km(3, 1));
        sb.push_back(4'h0);
        wait_pulse(100, kk, found);
        checks++;
        if (!found || kk != 16) $display("FAIL key0_latency: got found %0d cycle %0d expected cycle 16", found, kk);
        else passed++;
        for (int k = kk + 1; k <= 230; k++) begin
            @(negedge clk);
            if (k == 209 || k == 217) begin
                checks++;
                if (key_held !== 1'b1) $display("FAIL key0_held_k%0d: got %b expected 1", k, key_held);
                else passed++;
            end
            if (k == 218) begin
                checks++;
                if (key_held !== 1'b0 || col_out !== 4'b1011)
                    $display("FAIL key0_release: got h %b col %b expected 0 1011", key_held, col_out);
                else passed++;
            end
            if (k == 200 || k == 204 || k == 208) pressed[3][1] = 1'b0;
            if (k == 203 || k == 207) pressed[3][1] = 1'b1;
        end
        check_sb_empty("key0_pending");
    endtask

    task automatic test_multi_key();
        int kk; bit found;
        do_reset(km(0, 0) | km(1, 0));
        repeat (40) @(negedge clk);
        checks++;
        if (col_out !== 4'b1011 || key_code !== 4'h0)
            $display("FAIL multi_scan: got col %b code %h expected 1011 0", col_out, key_code);
        else passed++;
        pressed[1][0] = 1'b0;
        sb.push_back(4'h1);
        wait_pulse(100, kk, found);
        checks++;
        if (!found) $display("FAIL key1_pulse: got none expected pulse");
        else passed++;
        repeat (10) @(negedge clk);
        check_sb_empty("key1_pending");
    endtask

    task automatic test_reset_mid();
        int kk; bit found;
        do_reset(km(1, 1));
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({col_out, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_mid_debounce: got col %b code %h v %b h %b expected 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.push_back(4'h5);
        repeat (16) @(negedge clk);
        checks++;
        if (key_valid !== 1'b1) $display("FAIL pulse_before_reset: got %b expected 1", key_valid);
        else passed++;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({col_out, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_on_pulse: got col %b code %h v %b h %b expected 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(4'h5);
        wait_pulse(40, kk, found);
        checks++;
        if (!found || kk != 16) $display("FAIL repress_latency: got found %0d cycle %0d expected cycle 16", found, kk);
        else passed++;
        repeat (30) @(negedge clk);
        check_sb_empty("repress_pending");
    endtask

    initial begin
        checks = 0;
        passed = 0;
        prev_valid = 1'b0;
        rst = 1'b0;
        pressed = '0;
        test_reset();
        test_scan_cycle();
        test_press_steady();
        test_bounce_press();
        test_release_glitch();
        test_multi_key();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
